// File: rtl/mips_bus_initiator.sv
// mips_bus_initiator
//   Issues single-word read/write commands onto the MIPS CPU memory bus.
//   Honours waitrequest and a fixed read latency, and returns one response per command.
//
//   Optional feature: define WAITREQ_TIMEOUT_EN to abort a transfer after TIMEOUT
//   consecutive waitrequest cycles. The aborted command responds with rsp_error=1.
//
// Ports
//   clk, reset           rising-edge clock; asynchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (cmd_ready high only in IDLE)
//   cmd_write            1=write, 0=read
//   cmd_addr             byte address, bits [1:0] ignored
//   cmd_byteenable       lane enables, bit n covers data[8n+7:8n]
//   cmd_wdata            write data
//   rsp_valid            one-cycle pulse per completed command
//   rsp_rdata            masked read data (0 for writes/aborts), held until next response
//   rsp_error            timeout abort flag, valid with rsp_valid
//   busy                 high whenever not IDLE
//   address, read, write, byteenable, writedata, waitrequest, readdata   memory bus
module mips_bus_initiator #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_byteenable,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam int unsigned LAT_W = 3;
`ifdef WAITREQ_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t             state;
  logic               is_read;
  logic [LAT_W-1:0]   lat_cnt;
  logic [31:0]        rdata_q;
`ifdef WAITREQ_TIMEOUT_EN
  logic [TO_W-1:0]    to_cnt;
  logic               err_q;
`endif

  // Expand byte enables into a 32-bit lane mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Command sequencer: all outputs are registered in this one block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= 32'h0;
      byteenable <= 4'h0;
      writedata  <= 32'h0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'h0;
      rsp_error  <= 1'b0;
      is_read    <= 1'b0;
      lat_cnt    <= LAT_W'(0);
      rdata_q    <= 32'h0;
`ifdef WAITREQ_TIMEOUT_EN
      to_cnt     <= TO_W'(0);
      err_q      <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            address    <= {cmd_addr[31:2], 2'b00};
            byteenable <= cmd_byteenable;
            writedata  <= cmd_wdata;
            read       <= ~cmd_write;
            write      <= cmd_write;
            is_read    <= ~cmd_write;
            rdata_q    <= 32'h0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= REQ;
`ifdef WAITREQ_TIMEOUT_EN
            to_cnt     <= TO_W'(0);
            err_q      <= 1'b0;
`endif
          end
        end

        // Bus fields are untouched here, so they stay stable through stalls.
        REQ: begin
          if (!waitrequest) begin
            read  <= 1'b0;
            write <= 1'b0;
            if (is_read) begin
              lat_cnt <= LAT_W'(READ_LATENCY);
              state   <= RDWAIT;
            end else begin
              state   <= RESP;
            end
          end
`ifdef WAITREQ_TIMEOUT_EN
          // This stalled edge is the TIMEOUT-th consecutive one: abort.
          else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            read    <= 1'b0;
            write   <= 1'b0;
            err_q   <= 1'b1;
            rdata_q <= 32'h0;
            state   <= RESP;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end

        // lat_cnt==1 marks the edge READ_LATENCY cycles after acceptance.
        RDWAIT: begin
          lat_cnt <= lat_cnt - LAT_W'(1);
          if (lat_cnt == LAT_W'(1)) begin
            rdata_q <= readdata & lane_mask(byteenable);
            state   <= RESP;
          end
        end

        RESP: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= rdata_q;
`ifdef WAITREQ_TIMEOUT_EN
          rsp_error <= err_q;
`else
          rsp_error <= 1'b0;
`endif
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_bus_initiator.sv
// Bench for mips_bus_initiator: a small bus memory responder and a directed vector table.
// It also runs random commands checked against a word-array memory model,
// a mid-transaction reset, and (with WAITREQ_TIMEOUT_EN) a timeout abort.
module tb_mips_bus_initiator;

  localparam int unsigned LAT = 1;
  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_byteenable;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mips_bus_initiator #(.READ_LATENCY(LAT), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_byteenable(cmd_byteenable), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .busy(busy),
    .address(address), .read(read), .write(write), .byteenable(byteenable),
    .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata)
  );

  function automatic logic [31:0] lanes(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    return (old_w & ~lanes(be)) | (new_w & lanes(be));
  endfunction

  // Bus responder: 16-word memory, readdata valid one cycle after acceptance, noise otherwise.
  logic [31:0] mem [16];
  int acc_wr = 0;
  int acc_rd = 0;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      readdata <= $urandom;
    end else if (write && !waitrequest) begin
      mem[address[5:2]] <= merge(mem[address[5:2]], writedata, byteenable);
      acc_wr <= acc_wr + 1;
      readdata <= $urandom;
    end else if (read && !waitrequest) begin
      readdata <= mem[address[5:2]];
      acc_rd <= acc_rd + 1;
    end else begin
      readdata <= $urandom;
    end
  end

  // Reference memory: what the responder's memory should hold after each command.
  logic [31:0] ref_mem [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Issue one command and watch it to completion. lat counts clock edges from the
  // accepting edge to the edge at which rsp_valid is seen high (-1 if never).
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input int stall,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int strobes, output int accepts, output logic bus_ok);
    int cyc;
    int w0;
    int r0;
    bus_ok = 1'b1; strobes = 0; lat = -1; rdata = 32'h0; err = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_byteenable = be; cmd_wdata = wd;
    waitrequest = 1'b0;
    cyc = 0;
    while (!cmd_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    w0 = acc_wr; r0 = acc_rd;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom;
    cmd_byteenable = 4'($urandom); cmd_wdata = $urandom;
    waitrequest = (stall > 0);
    for (cyc = 0; cyc < 400; cyc++) begin
      if (read || write) begin
        strobes++;
        if (read && write) bus_ok = 1'b0;
        if (write !== wr) bus_ok = 1'b0;
        if (address !== {addr[31:2], 2'b00} || byteenable !== be) bus_ok = 1'b0;
        if (wr && writedata !== wd) bus_ok = 1'b0;
      end
      if (cyc == 0 && (cmd_ready !== 1'b0 || busy !== 1'b1)) bus_ok = 1'b0;
      if (rsp_valid) begin
        lat = cyc + 1; rdata = rsp_rdata; err = rsp_error;
        break;
      end
      @(negedge clk);
      waitrequest = (cyc + 1 < stall);
    end
    waitrequest = 1'b0;
    accepts = (acc_wr - w0) + (acc_rd - r0);
    @(negedge clk);
    if (rsp_valid !== 1'b0) bus_ok = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          stall;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t tbl [9];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        ok;
    int          lat;
    int          stb;
    int          acc;
    int          seen;
    int          r0;

    tbl[0] = '{1'b1, 32'hBFC00004, 4'hF, 32'hDEADBEEF, 0, 32'h0,        3};
    tbl[1] = '{1'b0, 32'hBFC00004, 4'hF, 32'h0,        0, 32'hDEADBEEF, 4};
    tbl[2] = '{1'b1, 32'hBFC00010, 4'hF, 32'h12345678, 0, 32'h0,        3};
    tbl[3] = '{1'b0, 32'hBFC00010, 4'h3, 32'h0,        0, 32'h00005678, 4};
    tbl[4] = '{1'b1, 32'hBFC00008, 4'hF, 32'h0000000A, 5, 32'h0,        8};
    tbl[5] = '{1'b0, 32'hBFC00008, 4'h0, 32'h0,        0, 32'h0,        4};
    tbl[6] = '{1'b1, 32'hBFC00010, 4'h5, 32'hAABBCCDD, 0, 32'h0,        3};
    tbl[7] = '{1'b0, 32'hBFC00013, 4'hF, 32'h0,        0, 32'h12BB56DD, 4};
    tbl[8] = '{1'b0, 32'hBFC00010, 4'hC, 32'h0,        2, 32'h12BB0000, 6};

    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
    cmd_byteenable = 4'h0; cmd_wdata = 32'h0; waitrequest = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_strobes", {30'd0, read, write}, 32'd0);
    check("rst_address", address, 32'h0);
    check("rst_be_wdata", {28'd0, byteenable} | writedata, 32'h0);
    check("rst_rsp", {30'd0, rsp_valid, rsp_error} | rsp_rdata, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      run_cmd(tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].wd, tbl[i].stall, rd, er, lat, stb, acc, ok);
      if (tbl[i].wr)
        ref_mem[tbl[i].addr[5:2]] = merge(ref_mem[tbl[i].addr[5:2]], tbl[i].wd, tbl[i].be);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      check($sformatf("vec%0d_error", i), 32'(er), 32'd0);
      check($sformatf("vec%0d_strobe_cycles", i), 32'(stb), 32'(1 + tbl[i].stall));
      check($sformatf("vec%0d_accepts", i), 32'(acc), 32'd1);
      check($sformatf("vec%0d_bus_ok", i), 32'(ok), 32'd1);
    end

    // Random commands against the word-array model.
    for (int n = 0; n < 40; n++) begin
      logic        wr;
      logic [3:0]  idx;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] addr;
      logic [31:0] exp_rd;
      int          stall;
      wr = 1'($urandom); idx = 4'($urandom); be = 4'($urandom); wd = $urandom;
      stall = int'($urandom_range(0, 3));
      addr = 32'hBFC00000 | {26'd0, idx, 2'($urandom)};
      if (wr) begin
        ref_mem[idx] = merge(ref_mem[idx], wd, be);
        exp_rd = 32'h0;
      end else begin
        exp_rd = ref_mem[idx] & lanes(be);
      end
      run_cmd(wr, addr, be, wd, stall, rd, er, lat, stb, acc, ok);
      check($sformatf("rand%0d_rdata", n), rd, exp_rd);
      check($sformatf("rand%0d_latency", n), 32'(lat), 32'(3 + stall + (wr ? 0 : int'(LAT))));
      check($sformatf("rand%0d_bus_ok", n), 32'(ok) & 32'(acc == 1), 32'd1);
    end

    // Reset while a read is stalled on the bus.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hBFC00004; cmd_byteenable = 4'hF;
    waitrequest = 1'b1;
    r0 = acc_rd;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_read_strobe", 32'(read), 32'd1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_read", 32'(read), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0; waitrequest = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("mid_rst_no_response", 32'(seen), 32'd0);
    check("mid_rst_no_accept", 32'(acc_rd - r0), 32'd0);
    run_cmd(1'b1, 32'hBFC00004, 4'hF, 32'h00000055, 0, rd, er, lat, stb, acc, ok);
    check("post_rst_write_latency", 32'(lat), 32'd3);
    run_cmd(1'b0, 32'hBFC00004, 4'hF, 32'h0, 1, rd, er, lat, stb, acc, ok);
    check("post_rst_read_rdata", rd, 32'h00000055);
    check("post_rst_read_latency", 32'(lat), 32'(3 + LAT + 1));

`ifdef WAITREQ_TIMEOUT_EN
    // Permanent stall: the strobe drops after TMO cycles and the command errors out.
    run_cmd(1'b1, 32'hBFC00008, 4'hF, 32'h11111111, 100000, rd, er, lat, stb, acc, ok);
    check("tmo_wr_strobe_cycles", 32'(stb), 32'(TMO));
    check("tmo_wr_error", 32'(er), 32'd1);
    check("tmo_wr_rdata", rd, 32'h0);
    check("tmo_wr_latency", 32'(lat), 32'(TMO + 2));
    check("tmo_wr_accepts", 32'(acc), 32'd0);
    run_cmd(1'b0, 32'hBFC00004, 4'hF, 32'h0, 100000, rd, er, lat, stb, acc, ok);
    check("tmo_rd_strobe_cycles", 32'(stb), 32'(TMO));
    check("tmo_rd_error", 32'(er), 32'd1);
    check("tmo_rd_rdata", rd, 32'h0);
    run_cmd(1'b0, 32'hBFC00004, 4'hF, 32'h0, 0, rd, er, lat, stb, acc, ok);
    check("tmo_after_rdata", rd, 32'h00000055);
    check("tmo_after_error", 32'(er), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
